alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX issue stage that drives the 32-bit ALU.
- Decodes an RV32I instruction and registers it with its fetched operands. Produces the ALU 4-bit select, operand A/B, and writeback/branch/memory side-band.
- Outputs are registered for the execute stage, with a valid/ready handshake on both sides and a pipeline flush.
- Sits between the register-file read and the ALU; the ALU consumes ex_sel/ex_a/ex_b and returns zeroflag to branch logic downstream (not to this block).

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  kill the held entry and any same-cycle acceptance
in_valid  input  1  upstream has an instruction
in_ready  output  1  stage can accept
in_instr  input  32  raw instruction
in_pc  input  32  instruction address
in_rs1  input  32  rs1 register value
in_rs2  input  32  rs2 register value
ex_valid  output  1  execute-stage entry valid
ex_ready  input  1  execute stage consumes entry
ex_sel  output  4  ALU op: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu
ex_a  output  32  ALU operand A
ex_b  output  32  ALU operand B
ex_rd  output  5  destination register
ex_wen  output  1  register writeback enable
ex_is_branch  output  1  conditional branch
ex_br_funct3  output  3  branch condition (instr[14:12])
ex_mem_rd  output  1  load
ex_mem_wr  output  1  store
ex_store_data  output  32  rs2 for stores
ex_illegal  output  1  undecodable instruction

Behaviour:
- Reset (rst_n low, asynchronous): every output register is 0, including ex_valid.
- in_ready is 1 from the first cycle after reset release.
- Transfer: accept = in_valid & in_ready. Without skid, in_ready = !ex_valid | ex_ready (combinational).
- Latency: accepted instruction appears on ex_* the next cycle with ex_valid=1.
- Hold: while ex_valid & !ex_ready, all ex_* are held stable.
- Pop without push clears ex_valid. Simultaneous pop and accept loads the new entry; no bubble.
- flush: next cycle ex_valid=0 and any same-cycle acceptance is dropped. Data fields may hold stale values.
- flush has priority over accept and ex_ready.
- Decode, opcode in_instr[6:0]:
  - 0110011 R-type: A=rs1, B=rs2, wen=1. funct3/funct7[5] map: 000/0 add, 000/1 sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101/0 srl, 101/1 sra, 110 or, 111 and.
  - R-type is illegal if funct7 is not 0000000/0100000, or if 0100000 is used with funct3 other than 000/101.
  - 0010011 I-ALU: B=sign-extended instr[31:20]. 000 is always add. Shifts use B={27'b0,instr[24:20]}, with instr[30] selecting sra.
  - I-ALU is illegal if a shift has funct7 other than 0000000/0100000.
  - 1100011 branch: A=rs1, B=rs2, wen=0, is_branch=1. beq/bne -> sub; blt/bge -> slt; bltu/bgeu -> sltu. funct3 010/011 is illegal.
  - 0000011 load: add, B=I-imm, mem_rd=1, wen=1.
  - 0100011 store: add, B=S-imm {instr[31:25],instr[11:7]} sign-extended, mem_wr=1, store_data=rs2, wen=0.
  - 0110111 LUI: add, A=0, B={instr[31:12],12'b0}, wen=1.
  - 0010111 AUIPC: add, A=pc, B=U-imm, wen=1.
  - Any other opcode is illegal.
- Illegal entries: sel=0000, A=B=0, wen=mem_rd=mem_wr=is_branch=0, ex_illegal=1. Still issued with ex_valid=1.
- ex_rd = instr[11:7]; wen is forced 0 when rd=0.
- Reset asserted mid-stall discards the held entry.

Optional Feature:
- Macro ALU_ISSUE_SKID_EN.
- Defined: adds a one-entry skid register and makes in_ready a registered signal equal to !skid_full.
  - An entry accepted while ex_valid & !ex_ready goes into skid.
  - On pop, skid moves to ex_*.
  - flush clears both entries.
  - Order is preserved; throughput stays 1/cycle.
- Undefined: no skid; in_ready is combinational as described above.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, ex_ready=1 -> next cycle ex_valid=1, sel=0000, a=5, b=7, rd=3, wen=1.
- srai x5,x6,4 (0x40435293), rs1=0x80000000 -> sel=0111, b=4, wen=1; bltu (funct3 110) -> sel=1001, is_branch=1, wen=0.
- Stall: ex_ready=0 for 3 cycles with in_valid=1 -> ex_* stable, in_ready=0 (no skid). Release -> two entries issue back-to-back in order.
- flush asserted in the same cycle as accept of lui x1,0x12345 -> next cycle ex_valid=0; afterwards the next instruction issues normally.
- Opcode 0x7F, and R-type funct7=0000001 -> ex_illegal=1, sel=0000, a=b=0, wen=0, ex_valid=1.
- With ALU_ISSUE_SKID_EN: stall with 2 inputs -> both held, in_ready falls one cycle later. rst_n pulled low mid-stall -> ex_valid=0 immediately and all outputs are 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I ALU/branch/memory ops for the ALU.
// Optional skid entry with registered in_ready: define ALU_ISSUE_SKID_EN.
package alu_issue_pkg;
  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_XOR  = 4'b0010;
  localparam logic [3:0] SEL_OR   = 4'b0011;
  localparam logic [3:0] SEL_AND  = 4'b0100;
  localparam logic [3:0] SEL_SLL  = 4'b0101;
  localparam logic [3:0] SEL_SRL  = 4'b0110;
  localparam logic [3:0] SEL_SRA  = 4'b0111;
  localparam logic [3:0] SEL_SLT  = 4'b1000;
  localparam logic [3:0] SEL_SLTU = 4'b1001;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_data;
    logic        illegal;
  } id_ex_t;
endpackage

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [3:0]      ex_sel,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_rd,
  output logic            ex_wen,
  output logic            ex_is_branch,
  output logic [2:0]      ex_br_funct3,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_illegal
);

  id_ex_t     dec;
  id_ex_t     ex;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] u_imm;
  logic [31:0] shamt;
  logic       ill;
  logic       accept;

  assign op    = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign u_imm = {in_instr[31:12], 12'b0};
  assign shamt = {27'b0, in_instr[24:20]};

  always_comb begin
    dec    = '0;
    ill    = 1'b0;
    dec.rd = in_instr[11:7];
    unique case (1'b1)
      (op == OP_R): begin
        dec.a   = in_rs1;
        dec.b   = in_rs2;
        dec.wen = 1'b1;
        unique case (f3)
          3'b000:  dec.sel = f7[5] ? SEL_SUB : SEL_ADD;
          3'b001:  dec.sel = SEL_SLL;
          3'b010:  dec.sel = SEL_SLT;
          3'b011:  dec.sel = SEL_SLTU;
          3'b100:  dec.sel = SEL_XOR;
          3'b101:  dec.sel = f7[5] ? SEL_SRA : SEL_SRL;
          3'b110:  dec.sel = SEL_OR;
          default: dec.sel = SEL_AND;
        endcase
        ill = !((f7 == 7'h00) ||
                ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      (op == OP_I): begin
        dec.a   = in_rs1;
        dec.b   = i_imm;
        dec.wen = 1'b1;
        unique case (f3)
          3'b000:  dec.sel = SEL_ADD;
          3'b001:  dec.sel = SEL_SLL;
          3'b010:  dec.sel = SEL_SLT;
          3'b011:  dec.sel = SEL_SLTU;
          3'b100:  dec.sel = SEL_XOR;
          3'b101:  dec.sel = in_instr[30] ? SEL_SRA : SEL_SRL;
          3'b110:  dec.sel = SEL_OR;
          default: dec.sel = SEL_AND;
        endcase
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          dec.b = shamt;
          ill   = !((f7 == 7'h00) || (f7 == 7'h20));
        end
      end
      (op == OP_BR): begin
        dec.a         = in_rs1;
        dec.b         = in_rs2;
        dec.is_branch = 1'b1;
        dec.br_funct3 = f3;
        unique case (f3[2:1])
          2'b00:   dec.sel = SEL_SUB;
          2'b10:   dec.sel = SEL_SLT;
          2'b11:   dec.sel = SEL_SLTU;
          default: ill = 1'b1;
        endcase
      end
      (op == OP_LD): begin
        dec.a      = in_rs1;
        dec.b      = i_imm;
        dec.mem_rd = 1'b1;
        dec.wen    = 1'b1;
      end
      (op == OP_ST): begin
        dec.a          = in_rs1;
        dec.b          = s_imm;
        dec.mem_wr     = 1'b1;
        dec.store_data = in_rs2;
      end
      (op == OP_LUI): begin
        dec.b   = u_imm;
        dec.wen = 1'b1;
      end
      (op == OP_AUI): begin
        dec.a   = in_pc;
        dec.b   = u_imm;
        dec.wen = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // illegal entries still issue, with a neutral payload
    if (ill) begin
      dec         = '0;
      dec.rd      = in_instr[11:7];
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) dec.wen = 1'b0;
  end

  assign accept = in_valid & in_ready;

`ifdef ALU_ISSUE_SKID_EN
  id_ex_t skid;
  logic   skid_full;

  assign in_ready = !skid_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex        <= '0;
      ex_valid  <= 1'b0;
      skid      <= '0;
      skid_full <= 1'b0;
    end else if (flush) begin
      ex_valid  <= 1'b0;
      skid_full <= 1'b0;
    end else if (!ex_valid || ex_ready) begin
      if (skid_full) begin
        ex        <= skid;
        ex_valid  <= 1'b1;
        skid_full <= 1'b0;
      end else if (accept) begin
        ex       <= dec;
        ex_valid <= 1'b1;
      end else begin
        ex_valid <= 1'b0;
      end
    end else if (accept) begin
      skid      <= dec;
      skid_full <= 1'b1;
    end
  end
`else
  assign in_ready = !ex_valid | ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex       <= '0;
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex       <= dec;
      ex_valid <= 1'b1;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end
`endif

  assign ex_sel        = ex.sel;
  assign ex_a          = ex.a;
  assign ex_b          = ex.b;
  assign ex_rd         = ex.rd;
  assign ex_wen        = ex.wen;
  assign ex_is_branch  = ex.is_branch;
  assign ex_br_funct3  = ex.br_funct3;
  assign ex_mem_rd     = ex.mem_rd;
  assign ex_mem_wr     = ex.mem_wr;
  assign ex_store_data = ex.store_data;
  assign ex_illegal    = ex.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed RV32I vectors,
// stall/flush/reset-mid-stall scenarios, optional ALU_ISSUE_SKID_EN.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        br;
    logic [2:0]  f3;
    logic        mrd;
    logic        mwr;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_sel;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        ex_is_branch;
  logic [2:0]  ex_br_funct3;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [31:0] ex_store_data;
  logic        ex_illegal;

  exp_t act;
  exp_t snap;
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_sel(ex_sel), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_is_branch(ex_is_branch),
    .ex_br_funct3(ex_br_funct3),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_store_data(ex_store_data),
    .ex_illegal(ex_illegal)
  );

  assign act = {ex_sel, ex_a, ex_b, ex_rd, ex_wen,
                ex_is_branch, ex_br_funct3, ex_mem_rd,
                ex_mem_wr, ex_store_data, ex_illegal};

  function automatic exp_t mk(
    input logic [3:0] sel, input logic [31:0] a,
    input logic [31:0] b, input logic [4:0] rd,
    input logic wen, input logic br, input logic [2:0] f3,
    input logic mrd, input logic mwr,
    input logic [31:0] sd, input logic ill);
    return {sel, a, b, rd, wen, br, f3, mrd, mwr, sd, ill};
  endfunction

  function automatic exp_t bad(input logic [4:0] rd);
    return mk(4'd0, 32'd0, 32'd0, rd, 1'b0, 1'b0, 3'd0,
              1'b0, 1'b0, 32'd0, 1'b1);
  endfunction

  function automatic exp_t alu(
    input logic [3:0] sel, input logic [31:0] a,
    input logic [31:0] b, input logic [4:0] rd, input logic wen);
    return mk(sel, a, b, rd, wen, 1'b0, 3'd0,
              1'b0, 1'b0, 32'd0, 1'b0);
  endfunction

  // monitor: every consumed entry must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL issue_extra act=%h exp=<none>", act);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL issue act=%h exp=%h", act, e);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr,
                      input logic [31:0] pc,
                      input logic [31:0] rs1,
                      input logic [31:0] rs2,
                      input exp_t e, input bit fl);
    bit done;
    done     = 1'b0;
    in_instr = instr;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_valid = 1'b1;
    flush    = fl;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!fl) q.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout act=0 exp=1");
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc    = '0;
    in_rs1   = '0;
    in_rs2   = '0;
    ex_ready = 1'b1;
    tick();
    tick();
    chk("reset_valid", ex_valid, 0);
    chk("reset_out", act, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    tick();

    send(32'h002081B3, 32'h0, 32'd5, 32'd7,
         alu(4'd0, 32'd5, 32'd7, 5'd3, 1'b1), 0);
    send(32'h40435293, 32'h4, 32'h80000000, 32'h11,
         alu(4'd7, 32'h80000000, 32'd4, 5'd5, 1'b1), 0);
    send(32'h0020E463, 32'h8, 32'd3, 32'd9,
         mk(4'd9, 32'd3, 32'd9, 5'd8, 1'b0, 1'b1, 3'd6,
            1'b0, 1'b0, 32'd0, 1'b0), 0);
    send(32'h0000017F, 32'hC, 32'd1, 32'd2, bad(5'd2), 0);
    send(32'h022081B3, 32'h10, 32'd1, 32'd2, bad(5'd3), 0);
    send(32'h40208233, 32'h14, 32'd10, 32'd3,
         alu(4'd1, 32'd10, 32'd3, 5'd4, 1'b1), 0);
    send(32'h00000013, 32'h18, 32'h55, 32'h66,
         alu(4'd0, 32'h55, 32'd0, 5'd0, 1'b0), 0);
    send(32'hFFF10093, 32'h1C, 32'h20, 32'h0,
         alu(4'd0, 32'h20, 32'hFFFFFFFF, 5'd1, 1'b1), 0);
    send(32'hFFC0A283, 32'h20, 32'h1000, 32'h0,
         mk(4'd0, 32'h1000, 32'hFFFFFFFC, 5'd5, 1'b1, 1'b0,
            3'd0, 1'b1, 1'b0, 32'd0, 1'b0), 0);
    send(32'hFE20AE23, 32'h24, 32'h2000, 32'hDEADBEEF,
         mk(4'd0, 32'h2000, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0,
            3'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0), 0);
    send(32'h00001397, 32'h100, 32'h9, 32'h9,
         alu(4'd0, 32'h100, 32'h1000, 5'd7, 1'b1), 0);
    send(32'h02109093, 32'h28, 32'd1, 32'd1, bad(5'd1), 0);
    send(32'h0020A463, 32'h2C, 32'd1, 32'd1, bad(5'd8), 0);
    send(32'h407352B3, 32'h30, 32'hF0000000, 32'd4,
         alu(4'd7, 32'hF0000000, 32'd4, 5'd5, 1'b1), 0);
    send(32'h4020C233, 32'h34, 32'd1, 32'd1, bad(5'd4), 0);
    send(32'h00435293, 32'h38, 32'h80000000, 32'd0,
         alu(4'd6, 32'h80000000, 32'd4, 5'd5, 1'b1), 0);
    send(32'h00208463, 32'h3C, 32'd4, 32'd4,
         mk(4'd1, 32'd4, 32'd4, 5'd8, 1'b0, 1'b1, 3'd0,
            1'b0, 1'b0, 32'd0, 1'b0), 0);

    // flush in the accept cycle drops lui
    send(32'h123450B7, 32'h40, 32'd0, 32'd0,
         alu(4'd0, 32'd0, 32'h12345000, 5'd1, 1'b1), 1);
    chk("flush_drop", ex_valid, 0);
    send(32'h00001397, 32'h44, 32'd0, 32'd0,
         alu(4'd0, 32'h44, 32'h1000, 5'd7, 1'b1), 0);
    drain();

    // stall with a second instruction waiting
    ex_ready = 1'b0;
    send(32'h002081B3, 32'h50, 32'd5, 32'd7,
         alu(4'd0, 32'd5, 32'd7, 5'd3, 1'b1), 0);
    snap = alu(4'd0, 32'd5, 32'd7, 5'd3, 1'b1);
`ifdef ALU_ISSUE_SKID_EN
    send(32'h40208233, 32'h54, 32'd10, 32'd3,
         alu(4'd1, 32'd10, 32'd3, 5'd4, 1'b1), 0);
`else
    in_instr = 32'h40208233;
    in_valid = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", ex_valid, 1);
      chk("stall_hold", act, snap);
      tick();
    end
    ex_ready = 1'b1;
`ifndef ALU_ISSUE_SKID_EN
    send(32'h40208233, 32'h54, 32'd10, 32'd3,
         alu(4'd1, 32'd10, 32'd3, 5'd4, 1'b1), 0);
`endif
    drain();

    // asynchronous reset while an entry is held
    ex_ready = 1'b0;
    send(32'hFFF10093, 32'h60, 32'h20, 32'h0,
         alu(4'd0, 32'h20, 32'hFFFFFFFF, 5'd1, 1'b1), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_stall_valid", ex_valid, 0);
    chk("rst_stall_out", act, 0);
    q.delete();
    tick();
    rst_n    = 1'b1;
    ex_ready = 1'b1;
    send(32'h00435293, 32'h64, 32'h80000000, 32'd0,
         alu(4'd6, 32'h80000000, 32'd4, 5'd5, 1'b1), 0);
    drain();
    tick();
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
